inst_mem_loader: RTL and testbench

// - Parametrised instruction memory for the experiment core. Replaces fixed,

---
 rtl/inst_mem_loader.sv | 134 +++++++++++++
 tb/tb_inst_mem_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: instruction memory filled from a host byte stream.
// Bytes arrive MSB-first, are packed into DATA_W words and written in order
// until END_MARK is stored (DONE) or DEPTH words arrive without it (ERR).
// The core is held in reset except in DONE. The fetch port has one cycle of
// read latency and reads the old contents when it hits the word being written.
// Optional feature: define INST_LOADER_CHECKSUM_EN to build a running XOR of
// all stored words; when undefined, checksum is tied to 0.
module inst_mem_loader #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 200,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] END_MARK = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              core_rstn,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] checksum
);

  localparam int              NB      = DATA_W / 8;
  localparam int              BC_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

  state_t              state, state_nxt;
  logic [BC_W-1:0]     bcnt;
  logic [DATA_W-1:0]   wr;
  logic [DATA_W+7:0]   shifted;
  logic [DATA_W-1:0]   word_nxt;
  logic                acc, last, wr_en;
  logic [ADDR_W:0]     cnt_inc;
  logic [DATA_W-1:0]   mem [DEPTH];

  // start always wins over a byte offered in the same cycle
  assign acc      = rx_valid & rx_ready & ~start;
  assign last     = (bcnt == BC_LAST);
  assign wr_en    = acc & last;
  assign shifted  = {wr, rx_data};
  assign word_nxt = shifted[DATA_W-1:0];
  assign cnt_inc  = load_count + CNT_ONE;

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    core_rstn = 1'b0;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        rx_ready = 1'b1;
        if (start)                        state_nxt = S_LOAD;
        else if (wr_en) begin
          if (word_nxt == END_MARK)       state_nxt = S_DONE;
          else if (cnt_inc == DEPTH_C)    state_nxt = S_ERR;
        end
      end
      S_DONE: begin
        core_rstn = 1'b1;
        load_done = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      S_ERR: begin
        load_err = 1'b1;
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // byte assembly and word counter; start discards any partial word
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bcnt       <= '0;
      load_count <= '0;
      wr         <= '0;
    end else if (start) begin
      bcnt       <= '0;
      load_count <= '0;
    end else if (acc) begin
      wr <= word_nxt;
      if (last) begin
        bcnt       <= '0;
        load_count <= cnt_inc;
      end else begin
        bcnt <= bcnt + BC_ONE;
      end
    end
  end

  // memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem[load_count[ADDR_W-1:0]] <= word_nxt;
  end

  // fetch port: nonblocking read gives old data on a same-cycle write
  always_ff @(posedge clk) begin
    if (!rstn)         fetch_inst <= '0;
    else if (fetch_en) fetch_inst <= ({1'b0, fetch_addr} < DEPTH_C) ? mem[fetch_addr] : '0;
  end

`ifdef INST_LOADER_CHECKSUM_EN
  // running XOR of stored words, cleared when a new load begins
  always_ff @(posedge clk) begin
    if (!rstn)      checksum <= '0;
    else if (start) checksum <= '0;
    else if (wr_en) checksum <= checksum ^ word_nxt;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed sequence with random
// words and byte gaps, checked against a program-level memory model.
module tb_inst_mem_loader;

  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, rx_valid = 1'b0, fetch_en = 1'b0;
  logic [7:0]  rx_data = '0, fetch_addr = '0;
  logic        rx_ready, core_rstn, load_done, load_err;
  logic [31:0] fetch_inst, checksum;
  logic [8:0]  load_count;

  inst_mem_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .fetch_inst(fetch_inst), .core_rstn(core_rstn), .load_done(load_done),
    .load_err(load_err), .load_count(load_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  bit [31:0]   mem_m [0:199];
  int          cnt_m;
  bit [31:0]   csum_m;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] exp_csum();
`ifdef INST_LOADER_CHECKSUM_EN
    return csum_m;
`else
    return 32'h0;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // model: a fully received word lands at the next free slot
  task automatic store_m(input bit [31:0] w);
    if (cnt_m < 200) begin
      mem_m[cnt_m] = w;
      cnt_m++;
      csum_m ^= w;
    end
  endtask

  task automatic send_word(input bit [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    store_m(w);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
    cnt_m = 0; csum_m = '0;
  endtask

  task automatic fetch(input int a, output logic [31:0] d);
    fetch_en = 1'b1; fetch_addr = a[7:0];
    tick();
    fetch_en = 1'b0;
    d = fetch_inst;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_core_rstn"}, 32'(core_rstn), 32'd1);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_count"}, 32'(load_count), 32'(cnt_m));
    chk({tag, "_csum"}, checksum, exp_csum());
  endtask

  task automatic check_mem(input string tag, input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      fetch(i, d);
      chk($sformatf("%s_mem%0d", tag, i), d, mem_m[i]);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_core_rstn"}, 32'(core_rstn), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_count"}, 32'(load_count), 32'd0);
    chk({tag, "_csum"}, checksum, 32'd0);
    chk({tag, "_fetch"}, fetch_inst, 32'd0);
  endtask

  initial begin
    logic [31:0] d, held, w;
    int n;

    // reset values
    repeat (2) tick();
    check_reset("rst");
    rstn = 1'b1;
    tick();

    // reference program
    pulse_start();
    chk("load_core_rstn_low", 32'(core_rstn), 32'd0);
    send_word(32'h20010014);
    send_word(32'h0c00000d);
    send_word(32'hffffffff);
    check_done("prog3");
    fetch(1, d);
    chk("prog3_fetch1", d, 32'h0c00000d);
    check_mem("prog3", 3);

    // checksum example
    pulse_start();
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'hffffffff);
    check_done("csum");
`ifdef INST_LOADER_CHECKSUM_EN
    chk("csum_value", checksum, 32'hfffffffc);
`else
    chk("csum_value", checksum, 32'h0);
`endif

    // out-of-range fetch and hold
    fetch(200, d); chk("fetch200", d, 32'h0);
    fetch(255, d); chk("fetch255", d, 32'h0);
    fetch(1, held); chk("fetch1", held, mem_m[1]);
    fetch_addr = 8'd0;
    repeat (2) tick();
    chk("fetch_hold", fetch_inst, held);

    // random programs
    for (int it = 0; it < 3; it++) begin
      pulse_start();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        w = $urandom();
        if (w == 32'hffffffff) w = 32'h0;
        send_word(w);
      end
      send_word(32'hffffffff);
      check_done($sformatf("rnd%0d", it));
      check_mem($sformatf("rnd%0d", it), cnt_m);
    end

    // fetch of the word being written returns old data
    held = mem_m[0];
    pulse_start();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    rx_valid = 1'b1; rx_data = 8'h78; fetch_en = 1'b1; fetch_addr = 8'd0;
    tick();
    rx_valid = 1'b0; fetch_en = 1'b0;
    chk("rbw_old", fetch_inst, held);
    store_m(32'h12345678);
    send_word(32'hffffffff);
    check_done("rbw");
    check_mem("rbw", 2);

    // start with a byte in the same LOAD cycle drops the byte
    pulse_start();
    send_byte(8'h99);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'haa;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    cnt_m = 0; csum_m = '0;
    send_word(32'hcafebabe);
    send_word(32'hffffffff);
    check_done("startdrop");
    check_mem("startdrop", 2);

    // partial word discarded by restart
    pulse_start();
    send_byte(8'h11); send_byte(8'h22);
    pulse_start();
    send_word(32'hffffffff);
    check_done("partial");
    fetch(0, d); chk("partial_mem0", d, 32'hffffffff);

    // overflow: DEPTH words without END_MARK
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      w = $urandom();
      if (w == 32'hffffffff) w = 32'h1;
      send_word(w);
    end
    chk("ovf_err", 32'(load_err), 32'd1);
    chk("ovf_done", 32'(load_done), 32'd0);
    chk("ovf_core_rstn", 32'(core_rstn), 32'd0);
    chk("ovf_rx_ready", 32'(rx_ready), 32'd0);
    chk("ovf_count", 32'(load_count), 32'd200);
    for (int k = 0; k < 4; k++) send_byte(8'hff);
    chk("ovf_ignored_count", 32'(load_count), 32'd200);
    chk("ovf_ignored_err", 32'(load_err), 32'd1);
    chk("ovf_csum", checksum, exp_csum());
    fetch(0, d);   chk("ovf_mem0", d, mem_m[0]);
    fetch(199, d); chk("ovf_mem199", d, mem_m[199]);

    // reset in the middle of a load
    pulse_start();
    send_byte(8'h55); send_byte(8'h66);
    rstn = 1'b0;
    tick();
    check_reset("midrst");
    rstn = 1'b1;
    tick();
    fetch(5, d); chk("midrst_mem5", d, mem_m[5]);
    fetch(0, d); chk("midrst_mem0", d, mem_m[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
